// File: rtl/bus_rr_pkg.sv
// Shared types and constants for the round-robin bus sequencer.
package bus_rr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Width of the programmable wait counter (WAIT_CYCLES up to 15).
  localparam int CNT_W = 4;

  // Pointer/index width; one bit minimum so NREQ=1 still has a legal vector.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_sequencer_if.sv
// Requester-side and bus-side signals of the sequencer bundled together.
// "master" is the sequencer's view; "slave" is the view of whoever drives
// the requests and models the bus slave.
interface bus_rr_sequencer_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               bus_ce;
  logic               bus_rd;
  logic               bus_wr;
  logic [AW-1:0]      bus_addr;
  logic [DW-1:0]      bus_wdata;
  logic [DW-1:0]      bus_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, bus_rdata,
    output gnt, done, rdata, busy, bus_ce, bus_rd, bus_wr, bus_addr, bus_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, bus_rdata,
    input  gnt, done, rdata, busy, bus_ce, bus_rd, bus_wr, bus_addr, bus_wdata
  );
endinterface

// File: rtl/bus_rr_sequencer_rr_pick.sv
// Round-robin winner select: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            any
);
  int j;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[PW'(j)]) begin
        any         = 1'b1;
        win[PW'(j)] = 1'b1;
        idx         = PW'(j);
      end
    end
  end
endmodule

// File: rtl/bus_rr_sequencer.sv
// Round-robin arbiter plus transaction sequencer for a shared simple bus.
// Each grant runs: arbitration (IDLE) -> strobes for WAIT_CYCLES+1 cycles
// (ACCESS) -> one completion cycle (DONE). All outputs are registered.
module bus_rr_sequencer
  import bus_rr_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  bus_rr_sequencer_if.master bus
);
  localparam int PW = ptr_w(NREQ);

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, widx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NREQ-1:0]  win, gnt, gnt_n, done, done_n;
  logic [DW-1:0]    rdata, rdata_n, wdata, wdata_n;
  logic [AW-1:0]    addr, addr_n;
  logic             ce, ce_n, rd, rd_n, wr, wr_n, busy, any;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .win (win),
    .idx (widx),
    .any (any)
  );

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    done_n  = '0;
    rdata_n = rdata;
    ce_n    = ce;
    rd_n    = rd;
    wr_n    = wr;
    addr_n  = addr;
    wdata_n = wdata;
    case (state)
      S_IDLE: begin
        gnt_n   = '0;
        ce_n    = 1'b0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        if (any) begin
          gnt_n   = win;
          ce_n    = 1'b1;
          wr_n    = bus.req_we[widx];
          rd_n    = ~bus.req_we[widx];
          addr_n  = bus.req_addr[widx*AW +: AW];
          wdata_n = bus.req_we[widx] ? bus.req_wdata[widx*DW +: DW] : '0;
          ptr_n   = (widx == PW'(NREQ-1)) ? '0 : widx + 1'b1;
          cnt_n   = CNT_W'(WAIT_CYCLES);
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          // Last strobe cycle: slave data is valid now, so capture reads here.
          if (rd) rdata_n = bus.bus_rdata;
          done_n  = gnt;
          ce_n    = 1'b0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      busy  <= 1'b0;
      ce    <= 1'b0;
      rd    <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      done  <= done_n;
      rdata <= rdata_n;
      busy  <= (state_n != S_IDLE);
      ce    <= ce_n;
      rd    <= rd_n;
      wr    <= wr_n;
      addr  <= addr_n;
      wdata <= wdata_n;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.done      = done;
  assign bus.rdata     = rdata;
  assign bus.busy      = busy;
  assign bus.bus_ce    = ce;
  assign bus.bus_rd    = rd;
  assign bus.bus_wr    = wr;
  assign bus.bus_addr  = addr;
  assign bus.bus_wdata = wdata;
endmodule

// File: tb/tb_bus_rr_sequencer.sv
// Bench for bus_rr_sequencer: three builds (WAIT_CYCLES 1, 0, 3) share the
// same requester stimulus; each has its own slave returning addr ^ 8'hB9.
module tb_bus_rr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [31:0] addr_v, wdata_v;
  int          n_pass = 0, n_total = 0;
  logic [7:0]  rexp;
  int          mptr;

  always #5 clk = ~clk;

  bus_rr_sequencer_if #(.NREQ(4), .AW(8), .DW(8)) if1 ();
  bus_rr_sequencer_if #(.NREQ(4), .AW(8), .DW(8)) if0 ();
  bus_rr_sequencer_if #(.NREQ(4), .AW(8), .DW(8)) if3 ();

  assign if1.req = req;  assign if1.req_we = we;  assign if1.req_addr = addr_v;  assign if1.req_wdata = wdata_v;
  assign if0.req = req;  assign if0.req_we = we;  assign if0.req_addr = addr_v;  assign if0.req_wdata = wdata_v;
  assign if3.req = req;  assign if3.req_we = we;  assign if3.req_addr = addr_v;  assign if3.req_wdata = wdata_v;
  assign if1.bus_rdata = (if1.bus_ce & if1.bus_rd) ? (if1.bus_addr ^ 8'hB9) : 8'h00;
  assign if0.bus_rdata = (if0.bus_ce & if0.bus_rd) ? (if0.bus_addr ^ 8'hB9) : 8'h00;
  assign if3.bus_rdata = (if3.bus_ce & if3.bus_rd) ? (if3.bus_addr ^ 8'hB9) : 8'h00;

  bus_rr_sequencer #(.NREQ(4), .AW(8), .DW(8), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  bus_rr_sequencer #(.NREQ(4), .AW(8), .DW(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  bus_rr_sequencer #(.NREQ(4), .AW(8), .DW(8), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst_n), .bus(if3));

  typedef struct {
    logic [3:0]  req, we;
    logic [31:0] addr, wdata;
    int          w;
    logic [7:0]  rexp;
  } vec_t;
  vec_t tbl[6];

  // {gnt, done, busy, ce, rd, wr, 4'h0, addr, wdata}
  function automatic logic [31:0] snap(input int sel);
    case (sel)
      0:       return {if0.gnt, if0.done, if0.busy, if0.bus_ce, if0.bus_rd, if0.bus_wr, 4'h0, if0.bus_addr, if0.bus_wdata};
      2:       return {if3.gnt, if3.done, if3.busy, if3.bus_ce, if3.bus_rd, if3.bus_wr, 4'h0, if3.bus_addr, if3.bus_wdata};
      default: return {if1.gnt, if1.done, if1.busy, if1.bus_ce, if1.bus_rd, if1.bus_wr, 4'h0, if1.bus_addr, if1.bus_wdata};
    endcase
  endfunction

  function automatic logic [7:0] rdata_of(input int sel);
    case (sel)
      0:       return if0.rdata;
      2:       return if3.rdata;
      default: return if1.rdata;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] g, input logic [3:0] d, input logic b,
                                     input logic ce, input logic rd, input logic wr,
                                     input logic [7:0] a, input logic [7:0] wd);
    return {g, d, b, ce, rd, wr, 4'h0, a, wd};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Round-robin reference: first requester at or after mptr, wrapping.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(mptr + k) % 4]) return (mptr + k) % 4;
    return -1;
  endfunction

  // Called at a negedge while the selected DUT is IDLE with inputs applied.
  // Expects: wt+1 strobe cycles, one done cycle, then back in IDLE.
  task automatic txn(input int sel, input int wt, input int w, input logic iswr,
                     input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd,
                     input bit scramble, input string nm);
    logic [3:0] g;
    g = 4'b0001 << w;
    chk({nm, " idle"}, snap(sel), 32'h0);
    for (int c = 0; c <= wt; c++) begin
      @(negedge clk);
      if (scramble && c == 0) begin
        req = 4'($urandom); we = 4'($urandom); addr_v = $urandom; wdata_v = $urandom;
      end
      chk({nm, " access"}, snap(sel), mk(g, 4'h0, 1'b1, 1'b1, ~iswr, iswr, a, iswr ? d : 8'h00));
    end
    @(negedge clk);
    chk({nm, " done"}, snap(sel), mk(g, g, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    chk({nm, " rdata"}, {24'h0, rdata_of(sel)}, {24'h0, exp_rd});
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; we = '0; addr_v = '0; wdata_v = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int w;
    req = '0; we = '0; addr_v = '0; wdata_v = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset w1", snap(1), 32'h0);
    chk("reset w0", snap(0), 32'h0);
    chk("reset w3", snap(2), 32'h0);
    chk("reset rdata", {24'h0, rdata_of(1)}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: all four held; expect 0,1,2,3,0,1 back to back.
    rexp = 8'h00;
    req = 4'hF; we = 4'b0101; addr_v = 32'h44332211; wdata_v = 32'hD4C3B2A1;
    for (int i = 0; i < 6; i++) begin
      w = i % 4;
      if (!we[w]) rexp = addr_v[w*8 +: 8] ^ 8'hB9;
      txn(1, 1, w, we[w], addr_v[w*8 +: 8], wdata_v[w*8 +: 8], rexp, 1'b0, "contend");
    end

    // Directed table; pointer is 2 after the contention run.
    tbl[0] = '{req: 4'b0100, we: 4'b0100, addr: 32'h00110000, wdata: 32'h00AA0000, w: 2, rexp: 8'h9B};
    tbl[1] = '{req: 4'b0010, we: 4'b0000, addr: 32'h00001200, wdata: 32'h0,        w: 1, rexp: 8'hAB};
    tbl[2] = '{req: 4'b0001, we: 4'b0001, addr: 32'h00000033, wdata: 32'h00000055, w: 0, rexp: 8'hAB};
    tbl[3] = '{req: 4'b0010, we: 4'b0000, addr: 32'h00004000, wdata: 32'h0,        w: 1, rexp: 8'hF9};
    tbl[4] = '{req: 4'b1001, we: 4'b1000, addr: 32'h77000003, wdata: 32'h5E000000, w: 3, rexp: 8'hF9};
    tbl[5] = '{req: 4'b1001, we: 4'b1000, addr: 32'h77000003, wdata: 32'h5E000000, w: 0, rexp: 8'hBA};
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req; we = tbl[i].we; addr_v = tbl[i].addr; wdata_v = tbl[i].wdata;
      w = tbl[i].w;
      txn(1, 1, w, tbl[i].we[w], tbl[i].addr[w*8 +: 8], tbl[i].wdata[w*8 +: 8], tbl[i].rexp, 1'b0, "table");
    end

    // Randomized traffic against the round-robin reference; pointer is now 1.
    mptr = 1;
    rexp = 8'hBA;
    for (int i = 0; i < 40; i++) begin
      req = 4'($urandom); we = 4'($urandom); addr_v = $urandom; wdata_v = $urandom;
      if (req == 4'h0) begin
        @(negedge clk);
        chk("rand idle", snap(1), 32'h0);
      end else begin
        w = model_pick(req);
        if (!we[w]) rexp = addr_v[w*8 +: 8] ^ 8'hB9;
        txn(1, 1, w, we[w], addr_v[w*8 +: 8], wdata_v[w*8 +: 8], rexp, bit'($urandom_range(0, 1)), "rand");
        mptr = (w + 1) % 4;
      end
    end

    // Reset during the first ACCESS cycle: outputs drop without a clock edge.
    req = 4'b0100; we = 4'b0000; addr_v = 32'h00660000;
    @(negedge clk);
    chk("pre-rst access", snap(1), mk(4'b0100, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 8'h00));
    rst_n = 1'b0;
    #1;
    chk("async rst", snap(1), 32'h0);
    req = '0;
    @(negedge clk);
    chk("rst no done", snap(1), 32'h0);
    rst_n = 1'b1;
    req = 4'b1010; we = 4'b0000; addr_v = 32'h21003400;
    txn(1, 1, 1, 1'b0, 8'h34, 8'h00, 8'h34 ^ 8'hB9, 1'b0, "post-rst");

    // WAIT_CYCLES=0 build: one strobe cycle, 3-cycle transaction.
    do_reset();
    req = 4'b0100; we = 4'b0000; addr_v = 32'h00120000;
    txn(0, 0, 2, 1'b0, 8'h12, 8'h00, 8'hAB, 1'b0, "wait0 read");
    req = '0;
    chk("wait0 rearb idle", snap(0), 32'h0);

    // WAIT_CYCLES=3 build: four strobe cycles.
    do_reset();
    req = 4'b0001; we = 4'b0001; addr_v = 32'h0000005C; wdata_v = 32'h000000E7;
    txn(2, 3, 0, 1'b1, 8'h5C, 8'hE7, 8'h00, 1'b0, "wait3 write");
    req = 4'b0011; we = 4'b0000; addr_v = 32'h00001200;
    txn(2, 3, 1, 1'b0, 8'h12, 8'h00, 8'hAB, 1'b0, "wait3 read");
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
